// File: rtl/gps_sim_source_pkg.sv
// Shared encodings and defaults for the simulated GPS fix source.
package gps_sim_pkg;
   localparam logic [1:0] SEL_POS = 2'd0;
   localparam logic [1:0] SEL_VEL = 2'd1;
   localparam logic [1:0] SEL_ACC = 2'd2;

   localparam int POS_INIT_DEF = 1000;
   localparam int VEL_INIT_DEF = 5;

   typedef enum logic {ST_EMPTY, ST_FULL} fix_state_t;
endpackage

// File: rtl/gps_sim_source_if.sv
// Fix output handshake: valid/ready plus packed per-channel snapshot and sequence number.
interface gps_sim_source_if #(
   parameter int W   = 32,
   parameter int NCH = 3
);
   logic                    fix_valid;
   logic                    fix_ready;
   logic [NCH-1:0][W-1:0]   fix_pos;
   logic [NCH-1:0][W-1:0]   fix_vel;
   logic [15:0]             fix_seq;

   modport master (output fix_valid, fix_pos, fix_vel, fix_seq, input fix_ready);
   modport slave  (input fix_valid, fix_pos, fix_vel, fix_seq, output fix_ready);
endinterface

// File: rtl/gps_sim_source_integrator.sv
// One axis: pos/vel/acc state, config write port and per-epoch integration.
module gps_axis_integrator
   import gps_sim_pkg::*;
#(
   parameter int              W        = 32,
   parameter int              SAT_EN   = 1,
   parameter logic [W-1:0]    POS_INIT = W'(POS_INIT_DEF),
   parameter logic [W-1:0]    VEL_INIT = W'(VEL_INIT_DEF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          we,
   input  logic [1:0]    sel,
   input  logic [W-1:0]  data,
   output logic [W-1:0]  pos_nxt,
   output logic [W-1:0]  vel_nxt
);
   logic [W-1:0] pos, vel, acc;
   logic [W-1:0] pos_n, vel_n, acc_n;

   // Overflow only when both operands share a sign the sum does not.
   function automatic logic [W-1:0] add(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] s;
      s = a + b;
      if (SAT_EN != 0 && a[W-1] == b[W-1] && s[W-1] != a[W-1])
         s = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return s;
   endfunction

   always_comb begin
      pos_n = pos;
      vel_n = vel;
      acc_n = acc;
      if (tick) begin
         pos_n = add(pos, vel);
         vel_n = add(vel, acc);
      end
      // A write on a tick cycle replaces only the addressed field's result.
      if (we) begin
         case (sel)
            SEL_POS: pos_n = data;
            SEL_VEL: vel_n = data;
            SEL_ACC: acc_n = data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos <= POS_INIT;
         vel <= VEL_INIT;
         acc <= '0;
      end else begin
         pos <= pos_n;
         vel <= vel_n;
         acc <= acc_n;
      end
   end

   assign pos_nxt = pos_n;
   assign vel_nxt = vel_n;
endmodule

// File: rtl/gps_sim_source.sv
// Simulated multi-axis GPS source: epoch timer, integrators and a one-deep fix output stage.
module gps_sim_source
   import gps_sim_pkg::*;
#(
   parameter int W        = 32,
   parameter int NCH      = 3,
   parameter int RATE_DIV = 10,
   parameter int SAT_EN   = 1,
   parameter int POS_INIT = POS_INIT_DEF,
   parameter int VEL_INIT = VEL_INIT_DEF,
   localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_we,
   input  logic [CW-1:0]    cfg_ch,
   input  logic [1:0]       cfg_sel,
   input  logic [W-1:0]     cfg_data,
   gps_sim_source_if.master fix,
   output logic             overrun
);
   logic [15:0]           cnt, seq;
   logic                  tick;
   fix_state_t            state;
   logic [NCH-1:0][W-1:0] pos_nxt, vel_nxt;

   assign tick = en && (cnt == 16'(RATE_DIV - 1));

   for (genvar i = 0; i < NCH; i++) begin : g_ax
      logic we_i;
      // Out-of-range channels match no instance, so they fall out as no-ops.
      assign we_i = cfg_we && (cfg_ch == CW'(i)) && (cfg_sel != 2'd3);

      gps_axis_integrator #(
         .W(W), .SAT_EN(SAT_EN), .POS_INIT(W'(POS_INIT)), .VEL_INIT(W'(VEL_INIT))
      ) u_ax (
         .clk(clk), .rst(rst), .tick(tick), .we(we_i), .sel(cfg_sel), .data(cfg_data),
         .pos_nxt(pos_nxt[i]), .vel_nxt(vel_nxt[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         seq         <= '0;
         state       <= ST_EMPTY;
         fix.fix_pos <= '0;
         fix.fix_vel <= '0;
         fix.fix_seq <= '0;
         overrun     <= 1'b0;
      end else begin
         if (en) cnt <= tick ? 16'd0 : cnt + 16'd1;
         if (tick) seq <= seq + 16'd1;
         case (state)
            ST_EMPTY: begin
               if (tick) begin
                  state       <= ST_FULL;
                  fix.fix_pos <= pos_nxt;
                  fix.fix_vel <= vel_nxt;
                  fix.fix_seq <= seq + 16'd1;
               end
            end
            ST_FULL: begin
               if (fix.fix_ready) begin
                  if (tick) begin
                     fix.fix_pos <= pos_nxt;
                     fix.fix_vel <= vel_nxt;
                     fix.fix_seq <= seq + 16'd1;
                  end else begin
                     state <= ST_EMPTY;
                  end
               end else if (tick) begin
                  // Oldest fix is kept; the new epoch is dropped and flagged.
                  overrun <= 1'b1;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   assign fix.fix_valid = (state == ST_FULL);
endmodule

// File: tb/tb_gps_sim_source.sv
// Bench for gps_sim_source: saturating and wrapping instances against an epoch-level model.
module tb_gps_sim_source;
   localparam int W   = 32;
   localparam int NCH = 3;
   localparam int RD  = 10;
   localparam int CW  = 2;
   localparam longint M    = longint'(1) << W;
   localparam longint MAXV = (M >> 1) - 1;
   localparam longint MINV = -(M >> 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, en, cfg_we, ready;
   logic [CW-1:0] cfg_ch;
   logic [1:0]    cfg_sel;
   logic [W-1:0]  cfg_data;
   logic          ovr_s, ovr_w;

   gps_sim_source_if #(.W(W), .NCH(NCH)) if_s ();
   gps_sim_source_if #(.W(W), .NCH(NCH)) if_w ();
   assign if_s.fix_ready = ready;
   assign if_w.fix_ready = ready;

   gps_sim_source #(.W(W), .NCH(NCH), .RATE_DIV(RD), .SAT_EN(1)) u_sat (
      .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .fix(if_s), .overrun(ovr_s));
   gps_sim_source #(.W(W), .NCH(NCH), .RATE_DIV(RD), .SAT_EN(0)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .fix(if_w), .overrun(ovr_w));

   int n_run = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference state: index 0 = saturating instance, 1 = wrapping instance.
   longint mp[2][NCH], mv[2][NCH], ma[2][NCH], ep[2][NCH], ev[2][NCH];
   int     mcnt, mseq, eseq;
   bit     evld, eovr;

   function automatic longint add(input longint a, input longint b, input int d);
      longint s = a + b;
      if (d == 0) begin
         if (s > MAXV) s = MAXV;
         if (s < MINV) s = MINV;
      end else begin
         s = s % M;
         if (s < 0) s += M;
         if (s > MAXV) s -= M;
      end
      return s;
   endfunction

   task automatic model_step();
      bit     tick;
      longint sd;
      longint np[2][NCH], nv[2][NCH];
      if (rst) begin
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++) begin
               mp[d][c] = 1000; mv[d][c] = 5; ma[d][c] = 0; ep[d][c] = 0; ev[d][c] = 0;
            end
         mcnt = 0; mseq = 0; eseq = 0; evld = 0; eovr = 0;
         return;
      end
      tick = en && (mcnt == RD - 1);
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < NCH; c++) begin
            np[d][c] = tick ? add(mp[d][c], mv[d][c], d) : mp[d][c];
            nv[d][c] = tick ? add(mv[d][c], ma[d][c], d) : mv[d][c];
         end
      sd = longint'($signed(cfg_data));
      if (cfg_we && int'(cfg_ch) < NCH && cfg_sel != 2'd3)
         for (int d = 0; d < 2; d++)
            case (cfg_sel)
               2'd0: np[d][cfg_ch] = sd;
               2'd1: nv[d][cfg_ch] = sd;
               default: ma[d][cfg_ch] = sd;
            endcase
      mp = np;
      mv = nv;
      if (en) mcnt = tick ? 0 : mcnt + 1;
      if (tick) mseq = (mseq + 1) % 65536;
      if (evld && !ready && tick) eovr = 1;
      else if (evld && ready && !tick) evld = 0;
      else if (tick) begin
         evld = 1; ep = np; ev = nv; eseq = mseq;
      end
   endtask

   task automatic cmp(input int d, input logic v, input logic o, input logic [15:0] s,
                      input logic [NCH-1:0][W-1:0] p, input logic [NCH-1:0][W-1:0] vv);
      logic [W-1:0] e;
      chk($sformatf("d%0d valid", d), 64'(v), 64'(evld));
      chk($sformatf("d%0d overrun", d), 64'(o), 64'(eovr));
      chk($sformatf("d%0d seq", d), 64'(s), 64'(eseq));
      for (int c = 0; c < NCH; c++) begin
         e = ep[d][c][W-1:0];
         chk($sformatf("d%0d pos%0d", d, c), 64'(p[c]), 64'(e));
         e = ev[d][c][W-1:0];
         chk($sformatf("d%0d vel%0d", d, c), 64'(vv[c]), 64'(e));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      cmp(0, if_s.fix_valid, ovr_s, if_s.fix_seq, if_s.fix_pos, if_s.fix_vel);
      cmp(1, if_w.fix_valid, ovr_w, if_w.fix_seq, if_w.fix_pos, if_w.fix_vel);
   endtask

   task automatic do_reset();
      rst = 1'b1; cfg_we = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   task automatic cfg(input int ch, input int sel, input logic [W-1:0] data);
      cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_sel = 2'(sel); cfg_data = data;
      cyc();
      cfg_we = 1'b0;
   endtask

   task automatic wait_fix(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!if_s.fix_valid && n < 4 * RD);
      if (!if_s.fix_valid) chk("fix_timeout", 64'd0, 64'd1);
   endtask

   int n;

   initial begin
      rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0; ready = 1'b1;
      do_reset();

      // Free run: one fix per epoch, position advancing by the reset velocity.
      en = 1'b1;
      for (int i = 0; i < 3 * RD; i++) begin
         cyc();
         if ((i + 1) % RD == 0) begin
            chk("run_vld", 64'(if_s.fix_valid), 64'd1);
            chk("run_seq", 64'(if_s.fix_seq), 64'((i + 1) / RD));
            chk("run_pos", 64'(if_s.fix_pos[1]), 64'(1000 + 5 * ((i + 1) / RD)));
            chk("run_vel", 64'(if_s.fix_vel[2]), 64'd5);
         end
      end

      // Acceleration on one channel only.
      do_reset();
      cfg(1, 2, 32'd2);
      wait_fix(n);
      chk("acc_vel1_a", 64'(if_s.fix_vel[1]), 64'd7);
      chk("acc_pos1_a", 64'(if_s.fix_pos[1]), 64'd1005);
      wait_fix(n);
      chk("acc_vel1_b", 64'(if_s.fix_vel[1]), 64'd9);
      chk("acc_pos1_b", 64'(if_s.fix_pos[1]), 64'd1012);
      chk("acc_pos0_b", 64'(if_s.fix_pos[0]), 64'd1010);
      chk("acc_vel2_b", 64'(if_s.fix_vel[2]), 64'd5);

      // Back-pressure across three ticks, then drain.
      do_reset();
      ready = 1'b0;
      wait_fix(n);
      chk("bp_seq1", 64'(if_s.fix_seq), 64'd1);
      chk("bp_ovr1", 64'(ovr_s), 64'd0);
      repeat (RD) cyc();
      chk("bp_ovr2", 64'(ovr_s), 64'd1);
      chk("bp_seq2", 64'(if_s.fix_seq), 64'd1);
      repeat (RD) cyc();
      chk("bp_seq3", 64'(if_s.fix_seq), 64'd1);
      ready = 1'b1;
      cyc();
      chk("bp_drain", 64'(if_s.fix_valid), 64'd0);
      wait_fix(n);
      chk("bp_seq4", 64'(if_s.fix_seq), 64'd4);

      // Positive overflow: clamp versus wrap.
      do_reset();
      en = 1'b0;
      cfg(0, 0, 32'h7FFF_FFF0);
      cfg(0, 1, 32'h0000_0020);
      en = 1'b1;
      wait_fix(n);
      chk("sat_pos", 64'(if_s.fix_pos[0]), 64'h7FFF_FFFF);
      chk("wrap_pos", 64'(if_w.fix_pos[0]), 64'h8000_0010);

      // Config write landing exactly on the tick cycle.
      do_reset();
      repeat (RD - 1) cyc();
      cfg(2, 1, 32'd100);
      chk("tw_vld", 64'(if_s.fix_valid), 64'd1);
      chk("tw_vel", 64'(if_s.fix_vel[2]), 64'd100);
      chk("tw_pos", 64'(if_s.fix_pos[2]), 64'd1005);
      wait_fix(n);
      chk("tw_pos2", 64'(if_s.fix_pos[2]), 64'd1105);

      // Reset mid-epoch while FULL with overrun set.
      do_reset();
      ready = 1'b0;
      repeat (2 * RD + 5) cyc();
      chk("mr_ovr_pre", 64'(ovr_s), 64'd1);
      rst = 1'b1;
      cyc();
      chk("mr_vld", 64'(if_s.fix_valid), 64'd0);
      chk("mr_ovr", 64'(ovr_s), 64'd0);
      chk("mr_pos", 64'(if_s.fix_pos), 64'd0);
      rst = 1'b0; ready = 1'b1;
      wait_fix(n);
      // Latency counted from the reset cycle itself.
      chk("mr_lat", 64'(n + 1), 64'(RD + 1));
      chk("mr_seq", 64'(if_s.fix_seq), 64'd1);

      // Randomized traffic, including occasional resets and out-of-range writes.
      do_reset();
      repeat (3000) begin
         rst      = ($urandom % 200) == 0;
         en       = ($urandom % 5) != 0;
         ready    = 1'($urandom % 2);
         cfg_we   = ($urandom % 8) == 0;
         cfg_ch   = CW'($urandom % 4);
         cfg_sel  = 2'($urandom % 4);
         cfg_data = ($urandom % 2) ? W'(int'($urandom_range(0, 64)) - 32) : W'($urandom);
         cyc();
      end
      rst = 1'b0; cfg_we = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/gps_sim_source.md
GPS_SIM_SOURCE -- requirements
Module: gps_sim_source

Interface
REQ-001 Parameter W, default 32: signed two's-complement width of position, velocity and acceleration.
REQ-002 Parameter NCH, default 3: number of independent axis channels.
REQ-003 Parameter RATE_DIV, default 10: clock cycles per fix epoch; legal range 2..65535.
REQ-004 Parameter SAT_EN, default 1: 1 saturates arithmetic at signed limits, 0 wraps modulo 2^W.
REQ-005 Parameter POS_INIT, default 1000: per-channel position reset value.
REQ-006 Parameter VEL_INIT, default 5: per-channel velocity reset value.
REQ-007 clk  in  1  single clock; all logic on the rising edge.
REQ-008 rst  in  1  reset, synchronous and active-high.
REQ-009 en  in  1  run enable; when low, the epoch counter and integration freeze.
REQ-010 cfg_we  in  1  single-cycle configuration write strobe.
REQ-011 cfg_ch  in  clog2(NCH) (minimum 1)  target channel.
REQ-012 cfg_sel  in  2  target field: 0 = pos, 1 = vel, 2 = acc, 3 = ignored.
REQ-013 cfg_data  in  W  write value.
REQ-014 fix_valid  out  1  output fix available.
REQ-015 fix_ready  in  1  consumer accepts the fix.
REQ-016 fix_pos  out  NCH*W  packed positions; channel 0 in the LSBs.
REQ-017 fix_vel  out  NCH*W  packed velocities; channel 0 in the LSBs.
REQ-018 fix_seq  out  16  epoch sequence number of the presented fix.
REQ-019 overrun  out  1  sticky: an epoch occurred while an unaccepted fix was held.

Function
REQ-020 The epoch counter counts 0..RATE_DIV-1 while en=1; tick = (en=1 and count=RATE_DIV-1); the counter wraps to 0 on tick.
REQ-021 On tick, each channel updates in one cycle: vel <= vel + acc, and pos <= pos + vel, using the pre-update vel.
REQ-022 With SAT_EN=1, each sum clamps to [-2^(W-1), 2^(W-1)-1]; with SAT_EN=0, each sum wraps.
REQ-023 An out-of-range cfg_ch, or cfg_sel=3, makes cfg_we a no-op.
REQ-024 A cfg_we landing on a tick cycle overrides the integration result for the addressed field only; all other fields integrate normally.
REQ-025 The epoch sequence counter increments by 1 on every tick and wraps 0xFFFF -> 0.
REQ-026 The output stage is a two-state FSM, EMPTY/FULL; fix_valid = (state == FULL).
REQ-027 EMPTY + tick -> FULL on the next cycle; fix_pos, fix_vel and fix_seq then carry the post-tick values (latency of one cycle after tick).
REQ-028 FULL + fix_ready -> EMPTY; if a tick occurs in that same cycle, the stage stays FULL and loads the new snapshot.
REQ-029 FULL + tick + !fix_ready -> stays FULL with the output held unchanged (oldest fix retained); overrun is set.
REQ-030 The output fields do not change while fix_valid=1 and fix_ready=0.
REQ-031 overrun clears only on rst.
REQ-032 en=0 does not affect the output handshake or configuration writes.

Reset
REQ-033 On rst, every channel's state resets to pos=POS_INIT, vel=VEL_INIT, acc=0.
REQ-034 On rst, the epoch counter resets to 0, the sequence counter to 0, the FSM to EMPTY, fix_valid to 0, fix_pos and fix_vel to 0, fix_seq to 0, and overrun to 0.
REQ-035 rst takes priority over cfg_we, tick and fix_ready in the same cycle.
REQ-036 An asserted rst mid-epoch discards the partial epoch; counting restarts from 0 on the first cycle after rst deasserts.

Structure
REQ-037 Package gps_sim_pkg holds the cfg_sel encodings (SEL_POS, SEL_VEL, SEL_ACC) and the default POS_INIT and VEL_INIT constants.
REQ-038 One sub-module, gps_axis_integrator (parameters W and SAT_EN), holds one channel's pos/vel/acc state, its config write port and its tick update; it is instantiated NCH times.
REQ-039 The epoch counter, sequence counter, output FSM and packing live in the top level.

Verification
REQ-040 Defaults, en=1 for 30 cycles, fix_ready=1: fixes at cycles 11, 21 and 31 after reset release, each with pos = 1005, 1010, 1015 and vel=5 on all channels, seq = 1, 2, 3.
REQ-041 Write acc=2 to ch1, then run two epochs: ch1 vel goes 7 then 9, pos goes 1005 then 1012; ch0 and ch2 are unchanged from the REQ-040 values.
REQ-042 Hold fix_ready=0 across three ticks: fix_seq stays 1, overrun=1 from the second tick; asserting fix_ready then drains once, and the next tick presents seq=4.
REQ-043 SAT_EN=1, write pos=0x7FFFFFF0 and vel=0x20, then tick: pos=0x7FFFFFFF. Same test with SAT_EN=0: pos=0x80000010.
REQ-044 cfg_we writing vel=100 in the same cycle as a tick: vel=100 and pos advances by the old vel of 5; the next tick advances pos by 100.
REQ-045 Assert rst mid-epoch while FULL with overrun=1: all outputs return to their reset values next cycle, and the first fix after release arrives RATE_DIV+1 cycles later with seq=1.
